// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the integer register file slice:
//   XLEN  - register / data width
//   NREGS - number of architectural registers (power of two)
//   AW    - register address width, log2(NREGS)
//   wbSel_e - write-back mux select encodings (pc, alu, mem, imm)
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef enum logic [1:0] {
        WB_PC  = 2'd0,
        WB_ALU = 2'd1,
        WB_MEM = 2'd2,
        WB_IMM = 2'd3
    } wbSel_e;

endpackage : riscv_pkg

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Tracks which integer registers have a write pending between issue and
// write-back, and raises a decode stall when a consumed source is pending.
//
// Ports:
//   clk, rst             - clock (rising edge), async active-high reset
//   issueValid, rdIssue  - issuing instruction marks rdIssue busy
//   wbValid, wbRd        - retiring write clears busy[wbRd]
//   rs1Addr/rs2Addr      - decode source addresses
//   rs1Used/rs2Used      - decode actually consumes the source
//   hazard               - combinational stall request to decode
//   busyVec              - registered busy snapshot, bit i = reg i pending
//
// Configuration macro: WB_BYPASS_EN - when defined, a register being
// retired this cycle no longer counts as busy for the hazard compare,
// because the read port forwards wbData on the same edge.
// ---------------------------------------------------------------------------
module wb_scoreboard
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issueValid,
    input  logic [AW-1:0]    rdIssue,
    input  logic             wbValid,
    input  logic [AW-1:0]    wbRd,
    input  logic [AW-1:0]    rs1Addr,
    input  logic [AW-1:0]    rs2Addr,
    input  logic             rs1Used,
    input  logic             rs2Used,
    output logic             hazard,
    output logic [NREGS-1:0] busyVec
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busyNext_s;
    logic [NREGS-1:0] busyEff_s;
    logic             rs1Hit_s;
    logic             rs2Hit_s;

    // Next busy vector: set beats clear on the same register (the issuing
    // instruction is the newer producer); x0 can never be busy.
    always_comb begin
        busyNext_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
            busyNext_s[i] = (issueValid && (rdIssue == AW'(i)) && (i != 0)) ? 1'b1 :
                            ((wbValid && (wbRd == AW'(i))) ? 1'b0 : busy_r[i]);
        end
        busyNext_s[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busyNext_s;
        end
    end

    // Busy view used for stalling; with forwarding, a register retiring now
    // is already readable and must not stall.
    always_comb begin
        busyEff_s = busy_r;
        for (int i = 0; i < NREGS; i++) begin
`ifdef WB_BYPASS_EN
            busyEff_s[i] = busy_r[i] & ~(wbValid && (wbRd == AW'(i)));
`else
            busyEff_s[i] = busy_r[i];
`endif
        end
    end

    // Source compare; address 0 never stalls.
    always_comb begin
        rs1Hit_s = rs1Used && (rs1Addr != {AW{1'b0}}) && busyEff_s[rs1Addr];
        rs2Hit_s = rs2Used && (rs2Addr != {AW{1'b0}}) && busyEff_s[rs2Addr];
    end

    assign hazard  = rs1Hit_s | rs2Hit_s;
    assign busyVec = busy_r;

endmodule : wb_scoreboard

// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
// Integer register file written straight from the write-back mux, with two
// registered read ports for decode and a built-in write scoreboard.
//
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   rdEn                     - capture both read ports on this edge
//   rs1Addr/rs2Addr          - read addresses
//   rs1Used/rs2Used          - decode consumes the source (hazard qualify)
//   rs1Data/rs2Data          - registered read data (1 cycle latency)
//   issueValid, rdIssue      - mark destination pending
//   wbValid, wbRd, wbData    - retiring register write
//   wbSel                    - select used by the write-back mux (debug only)
//   hazard                   - combinational decode stall
//   busyVec                  - pending-write snapshot
//   lastWbSel                - debug view of the last retired wbSel
//
// Configuration macro: WB_BYPASS_EN - same-cycle forwarding of wbData into
// the read ports and one-cycle-earlier hazard release. Undefined: reads see
// the pre-write register value.
// ---------------------------------------------------------------------------
module reg_file_wb
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdEn,
    input  logic [AW-1:0]    rs1Addr,
    input  logic [AW-1:0]    rs2Addr,
    input  logic             rs1Used,
    input  logic             rs2Used,
    output logic [XLEN-1:0]  rs1Data,
    output logic [XLEN-1:0]  rs2Data,
    input  logic             issueValid,
    input  logic [AW-1:0]    rdIssue,
    input  logic             wbValid,
    input  logic [AW-1:0]    wbRd,
    input  logic [XLEN-1:0]  wbData,
    input  logic [1:0]       wbSel,
    output logic             hazard,
    output logic [NREGS-1:0] busyVec,
    output logic [1:0]       lastWbSel
);

    logic [XLEN-1:0] regArray_r [NREGS];
    logic [XLEN-1:0] rs1Next_s;
    logic [XLEN-1:0] rs2Next_s;
    logic            wrEn_s;
    wbSel_e          lastWbSel_r;

    assign wrEn_s = wbValid && (wbRd != {AW{1'b0}});

    // Register array; entry 0 is never written so x0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regArray_r[i] <= {XLEN{1'b0}};
            end
        end else if (wrEn_s) begin
            regArray_r[wbRd] <= wbData;
        end
    end

    // Read-port data selection, including optional same-edge forwarding.
    always_comb begin
        rs1Next_s = (rs1Addr == {AW{1'b0}}) ? {XLEN{1'b0}} : regArray_r[rs1Addr];
        rs2Next_s = (rs2Addr == {AW{1'b0}}) ? {XLEN{1'b0}} : regArray_r[rs2Addr];
`ifdef WB_BYPASS_EN
        if (wrEn_s && (wbRd == rs1Addr)) begin
            rs1Next_s = wbData;
        end else begin
            rs1Next_s = rs1Next_s;
        end
        if (wrEn_s && (wbRd == rs2Addr)) begin
            rs2Next_s = wbData;
        end else begin
            rs2Next_s = rs2Next_s;
        end
`endif
    end

    // Registered read ports; hold when rdEn is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1Data <= {XLEN{1'b0}};
            rs2Data <= {XLEN{1'b0}};
        end else if (rdEn) begin
            rs1Data <= rs1Next_s;
            rs2Data <= rs2Next_s;
        end
    end

    // Debug capture of the write-back source; not on the data path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastWbSel_r <= WB_PC;
        end else if (wbValid) begin
            lastWbSel_r <= wbSel_e'(wbSel);
        end
    end

    assign lastWbSel = lastWbSel_r;

    wb_scoreboard uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issueValid),
        .rdIssue    (rdIssue),
        .wbValid    (wbValid),
        .wbRd       (wbRd),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .rs1Used    (rs1Used),
        .rs2Used    (rs2Used),
        .hazard     (hazard),
        .busyVec    (busyVec)
    );

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wb
// Directed self-checking bench for reg_file_wb. Expected read-port values
// are queued when a read is launched and popped when the read data is due.
// Honours WB_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_reg_file_wb;
    import riscv_pkg::*;

    logic             clk;
    logic             rst;
    logic             rdEn;
    logic [AW-1:0]    rs1Addr;
    logic [AW-1:0]    rs2Addr;
    logic             rs1Used;
    logic             rs2Used;
    logic [XLEN-1:0]  rs1Data;
    logic [XLEN-1:0]  rs2Data;
    logic             issueValid;
    logic [AW-1:0]    rdIssue;
    logic             wbValid;
    logic [AW-1:0]    wbRd;
    logic [XLEN-1:0]  wbData;
    logic [1:0]       wbSel;
    logic             hazard;
    logic [NREGS-1:0] busyVec;
    logic [1:0]       lastWbSel;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] expQ [$];

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_wb dut (
        .clk        (clk),
        .rst        (rst),
        .rdEn       (rdEn),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .rs1Used    (rs1Used),
        .rs2Used    (rs2Used),
        .rs1Data    (rs1Data),
        .rs2Data    (rs2Data),
        .issueValid (issueValid),
        .rdIssue    (rdIssue),
        .wbValid    (wbValid),
        .wbRd       (wbRd),
        .wbData     (wbData),
        .wbSel      (wbSel),
        .hazard     (hazard),
        .busyVec    (busyVec),
        .lastWbSel  (lastWbSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a read and record what both ports must return.
    task automatic launchRead(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
        rdEn    = 1'b1;
        rs1Addr = a1;
        rs2Addr = a2;
        expQ.push_back(e1);
        expQ.push_back(e2);
    endtask

    // Compare both read ports against the oldest queued expectations.
    task automatic checkRead(input string tag);
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        if (expQ.size() < 2) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=2_entries", tag);
        end else begin
            e1 = expQ.pop_front();
            e2 = expQ.pop_front();
            chk({tag, "_rs1"}, 64'(rs1Data), 64'(e1));
            chk({tag, "_rs2"}, 64'(rs2Data), 64'(e2));
        end
    endtask

    initial begin
        rst = 1'b1; rdEn = 1'b0; rs1Addr = 5'd0; rs2Addr = 5'd0;
        rs1Used = 1'b0; rs2Used = 1'b0; issueValid = 1'b0; rdIssue = 5'd0;
        wbValid = 1'b0; wbRd = 5'd0; wbData = 32'd0; wbSel = 2'd0;
        tick(); tick();
        chk("reset_busy", 64'(busyVec), 64'd0);
        chk("reset_rs1", 64'(rs1Data), 64'd0);
        chk("reset_hazard", 64'(hazard), 64'd0);
        rst = 1'b0;
        tick();

        // Write x3, then read it back one edge later.
        wbValid = 1'b1; wbRd = 5'd3; wbData = 32'hDEADBEEF; wbSel = WB_MEM;
        tick();
        wbValid = 1'b0;
        chk("wbsel_debug", 64'(lastWbSel), 64'd2);
        launchRead(5'd3, 5'd0, 32'hDEADBEEF, 32'd0);
        tick();
        checkRead("read_x3");

        // rdEn low holds the previous outputs.
        rdEn = 1'b0; rs1Addr = 5'd0;
        tick();
        chk("hold_rs1", 64'(rs1Data), 64'h0000_0000_DEAD_BEEF);

        // x0: write and issue to x0 are ignored.
        wbValid = 1'b1; wbRd = 5'd0; wbData = 32'h1234;
        issueValid = 1'b1; rdIssue = 5'd0;
        tick();
        wbValid = 1'b0; issueValid = 1'b0;
        chk("x0_busy", 64'(busyVec), 64'd0);
        rs1Used = 1'b1;
        launchRead(5'd0, 5'd0, 32'd0, 32'd0);
        chk("x0_hazard", 64'(hazard), 64'd0);
        tick();
        checkRead("read_x0");
        rdEn = 1'b0; rs1Used = 1'b0;

        // Hazard on x7 until its write-back retires.
        issueValid = 1'b1; rdIssue = 5'd7;
        tick();
        issueValid = 1'b0;
        chk("busy_x7", 64'(busyVec), 64'h80);
        rs2Addr = 5'd7; rs2Used = 1'b0;
        #1 chk("hazard_unused", 64'(hazard), 64'd0);
        rs2Used = 1'b1;
        #1 chk("hazard_x7", 64'(hazard), 64'd1);
        wbValid = 1'b1; wbRd = 5'd7; wbData = 32'h0000_0077; wbSel = WB_ALU;
        #1 chk("hazard_wb_cycle", 64'(hazard), BYP ? 64'd0 : 64'd1);
        tick();
        wbValid = 1'b0;
        chk("hazard_after_wb", 64'(hazard), 64'd0);
        chk("busy_after_wb", 64'(busyVec), 64'd0);
        launchRead(5'd0, 5'd7, 32'd0, 32'h77);
        tick();
        checkRead("read_x7");
        rdEn = 1'b0; rs2Used = 1'b0;

        // Set/clear collision on x9: set wins, data still written.
        issueValid = 1'b1; rdIssue = 5'd9;
        tick();
        wbValid = 1'b1; wbRd = 5'd9; wbData = 32'h99;
        tick();
        wbValid = 1'b0; issueValid = 1'b0;
        chk("collide_busy", 64'(busyVec), 64'h200);
        launchRead(5'd9, 5'd3, 32'h99, 32'hDEADBEEF);
        tick();
        checkRead("collide_read");
        rdEn = 1'b0;
        wbValid = 1'b1; wbRd = 5'd9; wbData = 32'h99;
        tick();
        wbValid = 1'b0;
        chk("collide_cleared", 64'(busyVec), 64'd0);

        // Same-edge write and read of x4.
        wbValid = 1'b1; wbRd = 5'd4; wbData = 32'h11;
        tick();
        wbData = 32'hA5A5A5A5;
        launchRead(5'd4, 5'd3, BYP ? 32'hA5A5A5A5 : 32'h11, 32'hDEADBEEF);
        tick();
        wbValid = 1'b0;
        checkRead("bypass_read");
        launchRead(5'd4, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick();
        checkRead("post_write_read");
        rdEn = 1'b0;

        // Reset mid-run with x5 pending clears everything immediately.
        issueValid = 1'b1; rdIssue = 5'd5;
        tick();
        issueValid = 1'b0;
        rs1Addr = 5'd5; rs1Used = 1'b1;
        #1 chk("pre_reset_hazard", 64'(hazard), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_busy", 64'(busyVec), 64'd0);
        chk("async_hazard", 64'(hazard), 64'd0);
        chk("async_rs1", 64'(rs1Data), 64'd0);
        chk("async_rs2", 64'(rs2Data), 64'd0);
        tick();
        rst = 1'b0; rs1Used = 1'b0;
        launchRead(5'd3, 5'd4, 32'd0, 32'd0);
        tick();
        checkRead("read_after_reset");
        rdEn = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_wb
